// File: rtl/ysyx_22050854_column_reducer_pkg.sv
// Shared constants for the Wallace column reducer: geometry, per-layer height table,
// FSM states and column/row bit indexing.
package ysyx_22050854_column_reducer_pkg;

  localparam int unsigned WIDTH  = 132;
  localparam int unsigned NPP    = 33;
  localparam int unsigned LAYERS = 8;
  localparam int unsigned COLS_W = WIDTH * NPP;
  localparam int unsigned CNT_W  = $clog2(LAYERS + 1);
  localparam int unsigned SEL_W  = $clog2(LAYERS);

  // Column height before each layer; entry LAYERS is the final height.
  localparam int unsigned HEIGHTS [LAYERS+1] = '{33, 22, 15, 10, 7, 5, 4, 3, 2};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_DONE
  } state_e;

  // Flat bit index of row `row` within column `col`.
  function automatic int unsigned col_bit(input int unsigned col, input int unsigned row);
    return col * NPP + row;
  endfunction

endpackage

// File: rtl/ysyx_22050854_csa_layer.sv
// One 3:2 carry-save layer over all columns; the layer index selects the column
// height the layer is built for.
module ysyx_22050854_csa_layer
  import ysyx_22050854_column_reducer_pkg::*;
(
  input  logic [COLS_W-1:0] cols_in,
  input  logic [SEL_W-1:0]  layer_sel,
  output logic [COLS_W-1:0] cols_out
);

  logic [COLS_W-1:0] layer_res [LAYERS];

  // Each height gets its own fixed wiring; the selected one is muxed out.
  for (genvar l = 0; l < LAYERS; l++) begin : g_layer
    localparam int unsigned H = HEIGHTS[l];
    localparam int unsigned F = H / 3;
    localparam int unsigned R = H % 3;

    logic [COLS_W-1:0] res;

    always_comb begin
      res = '0;
      for (int unsigned j = 0; j < WIDTH; j++) begin
        for (int unsigned k = 0; k < F; k++) begin
          res[col_bit(j, k)] = cols_in[col_bit(j, 3*k)] ^ cols_in[col_bit(j, 3*k+1)]
                             ^ cols_in[col_bit(j, 3*k+2)];
          if (j + 1 < WIDTH) begin
            res[col_bit(j+1, F+R+k)] =
                (cols_in[col_bit(j, 3*k)]   & cols_in[col_bit(j, 3*k+1)]) |
                (cols_in[col_bit(j, 3*k)]   & cols_in[col_bit(j, 3*k+2)]) |
                (cols_in[col_bit(j, 3*k+1)] & cols_in[col_bit(j, 3*k+2)]);
          end
        end
        for (int unsigned r = 0; r < 2; r++) begin
          if (r + 1 <= R) begin
            res[col_bit(j, F+r)] = cols_in[col_bit(j, 3*F+r)];
          end
        end
      end
    end

    assign layer_res[l] = res;
  end

  assign cols_out = layer_res[layer_sel];

endmodule

// File: rtl/ysyx_22050854_column_reducer.sv
// Wallace column reducer: loads WIDTH columns of NPP bits, applies one CSA layer per
// cycle down to two bits per column, then presents the sum and carry rows.
module ysyx_22050854_column_reducer
  import ysyx_22050854_column_reducer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH*NPP-1:0]  in_cols,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_sum,
  output logic [WIDTH-1:0]      out_carry
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [COLS_W-1:0] cols_q, cols_d;
  logic [COLS_W-1:0] layer_cols;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [WIDTH-1:0]  carry_q, carry_d;
  logic              valid_q, valid_d;

  ysyx_22050854_csa_layer u_layer (
    .cols_in   (cols_q),
    .layer_sel (cnt_q[SEL_W-1:0]),
    .cols_out  (layer_cols)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cols_d  = cols_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cols_d  = in_cols;
          cnt_d   = '0;
          state_d = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        // The counter runs one step past the last layer so the row latch reads
        // settled column regs, giving the LAYERS+1 cycle accept-to-valid latency.
        if (cnt_q == CNT_W'(LAYERS)) begin
          for (int unsigned j = 0; j < WIDTH; j++) begin
            sum_d[j]   = cols_q[col_bit(j, 0)];
            carry_d[j] = cols_q[col_bit(j, 1)];
          end
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cols_d = layer_cols;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cols_q  <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cols_q  <= cols_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_carry = carry_q;

endmodule

// File: tb/tb_ysyx_22050854_column_reducer.sv
// Self-checking bench for the column reducer against a popcount-weighted column model
// and a radix-4 Booth 64x64 product model.
module tb_ysyx_22050854_column_reducer;
  import ysyx_22050854_column_reducer_pkg::*;

  localparam int unsigned CW = WIDTH * NPP;
  localparam int MAX_LAT = 30;
  localparam int EXP_LAT = LAYERS + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_cols;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [WIDTH-1:0] out_carry;

  int passed = 0;
  int total  = 0;

  ysyx_22050854_column_reducer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cols   (in_cols),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry)
  );

  always #5 clk = ~clk;

  // Value represented by a column set: each bit of column j weighs 2^j.
  function automatic logic [WIDTH-1:0] col_weight(input logic [CW-1:0] c);
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] pc;
    acc = '0;
    for (int j = 0; j < int'(WIDTH); j++) begin
      pc  = WIDTH'($countones(c[j*NPP +: NPP]));
      acc = acc + (pc << j);
    end
    return acc;
  endfunction

  function automatic logic [CW-1:0] rand_cols();
    logic [CW-1:0] c;
    logic [31:0]   w;
    w = '0;
    for (int i = 0; i < int'(CW); i++) begin
      if (i % 32 == 0) w = $urandom;
      c[i] = w[i % 32];
    end
    return c;
  endfunction

  // Radix-4 Booth partial products of unsigned a*b, sign-extended to WIDTH and transposed.
  function automatic logic [CW-1:0] booth_cols(input logic [63:0] a, input logic [63:0] b);
    logic [65:0]      bx;
    logic [WIDTH-1:0] pp;
    logic [CW-1:0]    c;
    logic             lo;
    int               d;
    bx = {2'b00, b};
    c  = '0;
    for (int i = 0; i < int'(NPP); i++) begin
      if (i == 0) lo = 1'b0;
      else        lo = bx[2*i-1];
      d  = int'(lo) + int'(bx[2*i]) - 2 * int'(bx[2*i+1]);
      pp = '0;
      if (d == 1 || d == -1)      pp = WIDTH'(a);
      else if (d == 2 || d == -2) pp = WIDTH'(a) << 1;
      pp = pp << (2 * i);
      if (d < 0) pp = -pp;
      for (int j = 0; j < int'(WIDTH); j++) c[j*NPP + i] = pp[j];
    end
    return c;
  endfunction

  // Present cols until accepted; called #1 after a rising edge, returns #1 after the accept edge.
  task automatic send(input logic [CW-1:0] cols);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_cols  = cols;
    while (!in_ready && n < MAX_LAT) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_cols  = rand_cols();
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < MAX_LAT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_cols = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_sum !== '0) $display("FAIL reset_out_sum: got %h want 0", out_sum); else passed++;
    total++; if (out_carry !== '0) $display("FAIL reset_out_carry: got %h want 0", out_carry); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_zero();
    int lat;
    send('0);
    wait_out(lat);
    total++; if (lat != EXP_LAT) $display("FAIL zero_latency: got %0d want %0d", lat, EXP_LAT); else passed++;
    total++; if (out_sum !== '0) $display("FAIL zero_sum: got %h want 0", out_sum); else passed++;
    total++; if (out_carry !== '0) $display("FAIL zero_carry: got %h want 0", out_carry); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL zero_release_valid: got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL zero_release_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_single_bit();
    logic [CW-1:0] c;
    int lat;
    c = '0; c[0] = 1'b1;
    send(c);
    wait_out(lat);
    total++; if (!out_valid) $display("FAIL single_timeout: got out_valid=0 want 1"); else passed++;
    total++; if (out_sum !== WIDTH'(1)) $display("FAIL single_sum: got %h want 1", out_sum); else passed++;
    total++; if (out_carry !== '0) $display("FAIL single_carry: got %h want 0", out_carry); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_boundary();
    logic [CW-1:0]    c;
    logic [WIDTH-1:0] s, exp;
    int lat;
    c = '0; c[5*NPP +: 3] = 3'b111;
    exp = WIDTH'(8'h60);
    send(c);
    wait_out(lat);
    s = out_sum + out_carry;
    total++; if (s !== exp) $display("FAIL col5_sum: got %h want %h", s, exp); else passed++;
    @(posedge clk); #1;

    c = '0; c[(WIDTH-1)*NPP +: NPP] = '1;
    exp = '0; exp[WIDTH-1] = 1'b1;
    send(c);
    wait_out(lat);
    s = out_sum + out_carry;
    total++; if (s !== exp) $display("FAIL col131_sum: got %h want %h", s, exp); else passed++;
    @(posedge clk); #1;

    c = '1;
    exp = WIDTH'(0) - WIDTH'(33);
    send(c);
    wait_out(lat);
    s = out_sum + out_carry;
    total++; if (s !== exp) $display("FAIL all_ones_sum: got %h want %h", s, exp); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic [CW-1:0] c;
    int lat;
    int spurious;
    c = '0; c[0] = 1'b1;
    out_ready = 1'b0;
    send(c);
    wait_out(lat);
    total++; if (lat != EXP_LAT) $display("FAIL stall_latency: got %0d want %0d", lat, EXP_LAT); else passed++;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_cols  = rand_cols();
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); else passed++;
      total++; if (out_sum !== WIDTH'(1)) $display("FAIL stall_sum[%0d]: got %h want 1", i, out_sum); else passed++;
      total++; if (out_carry !== '0) $display("FAIL stall_carry[%0d]: got %h want 0", i, out_carry); else passed++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL stall_release_valid: got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", in_ready); else passed++;
    spurious = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) spurious++;
    end
    total++; if (spurious != 0) $display("FAIL stall_ignored_input: got %0d valid cycles want 0", spurious); else passed++;
  endtask

  task automatic test_abort();
    logic [CW-1:0]    c;
    logic [WIDTH-1:0] s, exp;
    int lat;
    int spurious;
    send(rand_cols());
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid: got %b want 0", out_valid); else passed++;
    spurious = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) spurious++;
    end
    total++; if (spurious != 0) $display("FAIL abort_no_output: got %0d valid cycles want 0", spurious); else passed++;
    c = rand_cols();
    exp = col_weight(c);
    send(c);
    wait_out(lat);
    s = out_sum + out_carry;
    total++; if (lat != EXP_LAT) $display("FAIL abort_next_latency: got %0d want %0d", lat, EXP_LAT); else passed++;
    total++; if (s !== exp) $display("FAIL abort_next_sum: got %h want %h", s, exp); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_random_cols();
    logic [CW-1:0]    c;
    logic [WIDTH-1:0] s, exp;
    int lat;
    for (int n = 0; n < 40; n++) begin
      c = rand_cols();
      exp = col_weight(c);
      out_ready = 1'b0;
      send(c);
      wait_out(lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      s = out_sum + out_carry;
      total++; if (s !== exp) $display("FAIL random_cols[%0d]: got %h want %h", n, s, exp); else passed++;
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0]      a, b;
    logic [WIDTH-1:0] s, exp;
    int lat;
    out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      case (n)
        0:       begin a = '0; b = '1; end
        1:       begin a = '1; b = '1; end
        2:       begin a = '1; b = 64'h8000_0000_0000_0000; end
        default: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
      endcase
      exp = WIDTH'(a) * WIDTH'(b);
      send(booth_cols(a, b));
      wait_out(lat);
      s = out_sum + out_carry;
      total++; if (lat != EXP_LAT) $display("FAIL b2b_latency[%0d]: got %0d want %0d", n, lat, EXP_LAT); else passed++;
      total++; if (s !== exp) $display("FAIL b2b_product[%0d]: got %h want %h", n, s, exp); else passed++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_cols = '0;
    @(posedge clk); #1;
    test_reset();
    test_zero();
    test_single_bit();
    test_boundary();
    test_stall();
    test_abort();
    test_random_cols();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
